// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// supported opcodes, ALU control codes, immediate formats and ALUOp classes.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALUOp classes produced by the FSM and consumed by alu_dec
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: maps the FSM's ALUOp class plus instruction funct
// fields onto a concrete ALU operation. Purely combinational.
module alu_dec
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op5,
    output logic [2:0] alu_ctrl
);

    // Subtract only for R-type with funct7[5] set; addi with a high
    // immediate bit has op5=0 and must stay an add.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath. Moore outputs per state,
// with MemReady gating the fetch strobes and Zero gating the branch PC write.
// Handshake: a memory access (FETCH, MEMREAD, MEMWRITE) completes on the
// cycle MemReady=1 is sampled at the rising edge; the FSM holds its state
// and its address/select outputs until then. Strobes are forced low while
// reset is high.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUCtrl,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] state_dbg
);

    // Width documents the datapath this controller drives; reject nonsense.
    if (Width < 8) begin : g_width_check
        $error("multicycle_controller: Width must be at least 8");
    end

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_write_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       illegal_c;

    // State register; reset returns to FETCH from any state immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state and per-state select/strobe decode
    always_comb begin
        state_next  = S_FETCH;
        alu_op      = ALUOP_ADD;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = MemReady;
                pc_write_c = MemReady;
                state_next = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        state_next = S_FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_next  = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = ALUOP_SUB;
                pc_write_c = Zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode regardless of state
    always_comb begin
        case (opcode)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_dec u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .op5      (opcode[5]),
        .alu_ctrl (ALUCtrl)
    );

    assign PCWrite   = pc_write_c  & ~reset;
    assign MemWrite  = mem_write_c & ~reset;
    assign IRWrite   = ir_write_c  & ~reset;
    assign RegWrite  = reg_write_c & ~reset;
    assign Illegal   = illegal_c   & ~reset;
    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The driver applies one
// cycle of inputs at a time and queues the hand-computed output vector for
// that cycle; the monitor pops and compares on every falling edge.
module tb_multicycle_controller;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MWR = 4'd5;
    localparam logic [3:0] ER  = 4'd6;
    localparam logic [3:0] EI  = 4'd7;
    localparam logic [3:0] AW  = 4'd8;
    localparam logic [3:0] BQ  = 4'd9;
    localparam logic [3:0] JL  = 4'd10;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUCtrl;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] state_dbg;

    logic [20:0] act;
    logic [20:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    multicycle_controller #(.Width(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUCtrl   (ALUCtrl),
        .RegWrite  (RegWrite),
        .Illegal   (Illegal),
        .state_dbg (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUCtrl, RegWrite, Illegal};

    // Packs one hand-written expected output vector (same field order as act)
    function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw,
                                       input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] ac,
                                       input logic rw, input logic ill);
        return {st, pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
    endfunction

    // Driver: apply one cycle of inputs, queue its expected outputs
    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic mr, input logic rst,
                       input logic [20:0] e, input string nm);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        Zero     = z;
        MemReady = mr;
        reset    = rst;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Four-cycle ALU instruction: FETCH, DECODE, execute, ALUWB
    task automatic alu_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [20:0] ex, input string nm);
        cyc(op, f3, f7, 1'b0, 1'b1, 1'b0, mk(F, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), {nm, "_fetch"});
        cyc(op, f3, f7, 1'b0, 1'b1, 1'b0, mk(D, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0), {nm, "_decode"});
        cyc(op, f3, f7, 1'b0, 1'b1, 1'b0, ex, {nm, "_exec"});
        cyc(op, f3, f7, 1'b0, 1'b1, 1'b0, mk(AW, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), {nm, "_wb"});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_mis++;
                $display("FAIL %s: got %b required %b", nm, act, e);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        opcode   = OPC_I;
        funct3   = 3'b000;
        funct7_5 = 1'b0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(posedge clk);
        #1;

        // reset held: FETCH selects, strobes low despite MemReady=1
        cyc(OPC_I, 3'b000, 0, 0, 1, 1, mk(F, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "reset_hold0");
        cyc(OPC_I, 3'b000, 0, 0, 1, 1, mk(F, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "reset_hold1");

        // I-type variants
        alu_instr(OPC_I, 3'b000, 0, mk(EI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0), "addi");
        alu_instr(OPC_I, 3'b000, 1, mk(EI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0), "addi_f7");
        alu_instr(OPC_I, 3'b010, 0, mk(EI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101, 0, 0), "slti");
        alu_instr(OPC_I, 3'b111, 0, mk(EI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0, 0), "andi");

        // R-type variants
        alu_instr(OPC_R, 3'b000, 1, mk(ER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0, 0), "sub");
        alu_instr(OPC_R, 3'b000, 0, mk(ER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0), "add");
        alu_instr(OPC_R, 3'b110, 0, mk(ER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011, 0, 0), "or");
        alu_instr(OPC_R, 3'b001, 0, mk(ER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0, 0), "r_other");

        // lw: one FETCH stall, two MEMREAD stalls
        cyc(OPC_LW, 3'b010, 0, 0, 0, 0, mk(F,   0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "lw_fetch_stall");
        cyc(OPC_LW, 3'b010, 0, 0, 1, 0, mk(F,   1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "lw_fetch");
        cyc(OPC_LW, 3'b010, 0, 0, 1, 0, mk(D,   0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0), "lw_decode");
        cyc(OPC_LW, 3'b010, 0, 0, 1, 0, mk(MA,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0), "lw_memadr");
        cyc(OPC_LW, 3'b010, 0, 0, 0, 0, mk(MR,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), "lw_memread0");
        cyc(OPC_LW, 3'b010, 0, 0, 0, 0, mk(MR,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), "lw_memread1");
        cyc(OPC_LW, 3'b010, 0, 0, 1, 0, mk(MR,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), "lw_memread2");
        cyc(OPC_LW, 3'b010, 0, 0, 1, 0, mk(MWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), "lw_memwb");

        // sw: no RegWrite, back to FETCH
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(F,   1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), "sw_fetch");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(D,   0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0), "sw_decode");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(MA,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0), "sw_memadr");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(MWR, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0), "sw_memwrite");

        // beq taken, then not taken
        cyc(OPC_BEQ, 3'b000, 0, 1, 1, 0, mk(F,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0), "beq_t_fetch");
        cyc(OPC_BEQ, 3'b000, 0, 1, 1, 0, mk(D,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0), "beq_t_decode");
        cyc(OPC_BEQ, 3'b000, 0, 1, 1, 0, mk(BQ, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0), "beq_taken");
        cyc(OPC_BEQ, 3'b000, 0, 0, 1, 0, mk(F,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0), "beq_n_fetch");
        cyc(OPC_BEQ, 3'b000, 0, 0, 1, 0, mk(D,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0), "beq_n_decode");
        cyc(OPC_BEQ, 3'b000, 0, 0, 1, 0, mk(BQ, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0), "beq_not_taken");

        // jal
        cyc(OPC_JAL, 3'b000, 0, 0, 1, 0, mk(F,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0), "jal_fetch");
        cyc(OPC_JAL, 3'b000, 0, 0, 1, 0, mk(D,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0, 0), "jal_decode");
        cyc(OPC_JAL, 3'b000, 0, 0, 1, 0, mk(JL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0), "jal_exec");
        cyc(OPC_JAL, 3'b000, 0, 0, 1, 0, mk(AW, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 0), "jal_wb");

        // unsupported opcode: Illegal pulse in DECODE, then FETCH
        cyc(OPC_BAD, 3'b000, 0, 0, 1, 0, mk(F, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "bad_fetch");
        cyc(OPC_BAD, 3'b000, 0, 0, 1, 0, mk(D, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 1), "bad_decode");
        cyc(OPC_BAD, 3'b000, 0, 0, 0, 0, mk(F, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0), "bad_refetch");

        // reset asserted in the middle of a stalled MEMWRITE
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(F,   1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), "rst_sw_fetch");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(D,   0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0), "rst_sw_decode");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(MA,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0), "rst_sw_memadr");
        cyc(OPC_SW, 3'b010, 0, 0, 0, 0, mk(MWR, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0), "rst_sw_memwrite");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 1, mk(F,   0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), "rst_mid_write");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(F,   1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0), "rst_release");
        cyc(OPC_SW, 3'b010, 0, 0, 1, 0, mk(D,   0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0), "rst_after_decode");

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: got %0d queued required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
